fir_mac_sequencer: RTL
======================

Name: fir_mac_sequencer

Overview:
- Central controller for the 40-tap FIR datapath, which has four single-port coefficient SRAM banks of 10 words each and four MAC units.
- On each 600 kHz sample strobe it does four things in order:
  - shifts the delay chain;
  - walks the 10 coefficient addresses across all four banks in parallel;
  - drives the MAC multiply, add and clear enables with matching pipeline delay;
  - signals the final sum stage when the result is complete.
- Between samples it serializes host coefficient writes into the correct bank.

Parameters:
- TAPS_PER_BANK, 10, coefficient words per SRAM bank and taps per MAC.
- NUM_TAPS, 40, total filter taps (4 x TAPS_PER_BANK).
- ADDR_W, 4, SRAM word-address width.

Ports:
- iClk12M  in  1  12 MHz clock; the only clock.
- iRsn  in  1  reset; synchronous, active-high.
- iEnSample600k  in  1  one-cycle sample strobe.
- iCoeffUpdateFlag  in  1  host coefficient-write mode request; level signal.
- iAddrRam  in  6  host global coefficient index, 0..39.
- iWrDtRam  in  16  host coefficient data.
- iNumOfCoeff  in  6  number of active taps, 0..40.
- oCsnRam  out  4  per-bank SRAM chip select, active-low.
- oWrnRam  out  4  per-bank SRAM write strobe, active-low (0 = write).
- oAddrRam  out  16  four 4-bit bank addresses; bank b occupies bits [4b+3:4b].
- oWrDtRam  out  16  SRAM write data, shared by all banks.
- oEnDelay  out  1  delay-chain shift enable.
- oEnAcc  out  4  per-MAC accumulator clear.
- oEnMul  out  4  per-MAC multiply enable.
- oEnAdd  out  4  per-MAC accumulate enable.
- oTapSel  out  4  delay-tap index 0..9 selected by each MAC for its multiply.
- oSumValid  out  1  one-cycle pulse: all MAC accumulators are final.
- oBusy  out  1  high in any state other than IDLE.
- oSampleDrop  out  1  one-cycle pulse: a sample strobe was ignored.

Behaviour:
- All outputs are registered.
- Reset values:
  - oCsnRam = 4'hF, oWrnRam = 4'hF, oAddrRam = 0, oWrDtRam = 0.
  - All enables = 0, oTapSel = 0, oSumValid = 0, oBusy = 0, oSampleDrop = 0.
  - State = IDLE.
- Reset mid-operation aborts immediately: no oSumValid is issued and no SRAM write completes after reset.
- States: IDLE, UPDATE, SHIFT, READ, FLUSH, DONE.
- IDLE:
  - iCoeffUpdateFlag=1 goes to UPDATE. It has priority over a simultaneous sample strobe, which is dropped (oSampleDrop pulses).
  - Otherwise iEnSample600k=1 goes to SHIFT.
- UPDATE:
  - For each cycle with the flag high, the block issues one write, registered (visible on the next cycle):
    - bank = iAddrRam/10, word = iAddrRam mod 10;
    - only that bank gets Csn=0 and Wrn=0, with its address = word and oWrDtRam = iWrDtRam.
  - iAddrRam >= 40: no write is issued; all Csn stay 1.
  - Flag low: return to IDLE with Csn/Wrn = 1.
  - Sample strobes in this state are dropped with oSampleDrop.
- SHIFT (1 cycle):
  - oEnDelay = 1.
  - oEnAcc = 4'hF (clears all accumulators).
  - Latch N = min(iNumOfCoeff, 40); tap counter k = 0.
- READ (10 cycles, k = 0..9):
  - Bank b is active when b*10 + k < N.
  - Active banks: Csn=0, Wrn=1, addr = k. Inactive banks: Csn=1.
- MAC pipeline:
  - The read issued at cycle t returns data at t+1.
  - At t+1: oEnMul[b] = 1 and oTapSel = k.
  - At t+2: oEnAdd[b] = 1.
  - Enables are asserted only for active banks.
- FLUSH (2 cycles): drains the pipeline.
- DONE (1 cycle): oSumValid = 1, then return to IDLE.
- Latency: oSumValid is asserted exactly 14 cycles after the cycle in which the strobe is sampled. This fits the 20-cycle sample period.
- A sample strobe while in SHIFT/READ/FLUSH/DONE is dropped (oSampleDrop) and does not restart the sequence.
- iCoeffUpdateFlag rising mid-sequence is honored after DONE: the block goes to UPDATE instead of IDLE.
- N = 0: the sequence still runs and oSumValid pulses, but oEnMul and oEnAdd stay 0.
- iNumOfCoeff changes mid-sequence have no effect; N is latched in SHIFT.

Test Plan:
- Reset held 3 cycles during READ -> all Csn = 1, no enables, no oSumValid; state IDLE on the first cycle after reset is released.
- Update mode, writes to indices 0, 9, 10, 39, 45 -> respectively:
  - bank0 addr 0;
  - bank0 addr 9;
  - bank1 addr 0;
  - bank3 addr 9;
  - no write (all Csn = 1).
  - Each write appears on the next cycle with Wrn = 0.
- N = 40, one strobe -> oEnDelay pulse at +1; READ runs k = 0..9 on all banks; oEnMul = 4'hF for cycles +3..+12; oEnAdd = 4'hF for cycles +4..+13; oSumValid at +14.
- N = 23 -> banks 0 and 1 are active for all k; bank 2 is active only for k = 0..2; bank 3's Csn stays 1 throughout.
- Second strobe at +5 and a strobe during UPDATE -> each produces an oSampleDrop pulse; only one oSumValid results from the first strobe.
- Flag and strobe in the same IDLE cycle -> UPDATE is entered and oSampleDrop pulses; flag raised at +8 -> UPDATE is entered right after DONE.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// 40-tap FIR controller: delay shift, 4-bank coefficient read walk, MAC enables, host coefficient writes.
// oSumValid 14 cycles after an accepted strobe; no backpressure, strobes arriving while busy or updating are dropped.
module fir_mac_sequencer #(
    parameter int TAPS_PER_BANK = 10,
    parameter int NUM_TAPS      = 40,
    parameter int ADDR_W        = 4
) (
    input  logic                iClk12M,
    input  logic                iRsn,
    input  logic                iEnSample600k,
    input  logic                iCoeffUpdateFlag,
    input  logic [5:0]          iAddrRam,
    input  logic [15:0]         iWrDtRam,
    input  logic [5:0]          iNumOfCoeff,
    output logic [3:0]          oCsnRam,
    output logic [3:0]          oWrnRam,
    output logic [4*ADDR_W-1:0] oAddrRam,
    output logic [15:0]         oWrDtRam,
    output logic                oEnDelay,
    output logic [3:0]          oEnAcc,
    output logic [3:0]          oEnMul,
    output logic [3:0]          oEnAdd,
    output logic [3:0]          oTapSel,
    output logic                oSumValid,
    output logic                oBusy,
    output logic                oSampleDrop
);
    localparam int NUM_BANKS = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_UPDATE = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_READ   = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [5:0]          n_q, n_d;
    logic                flush_q, flush_d;

    logic [3:0]          csn_q, csn_d;
    logic [3:0]          wrn_q, wrn_d;
    logic [4*ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]         wdt_q, wdt_d;
    logic                dly_q, dly_d;
    logic [3:0]          acc_q, acc_d;
    logic [3:0]          rd_act_q, rd_act_d;
    logic [ADDR_W-1:0]   rd_k_q;
    logic [3:0]          mul_q;
    logic [3:0]          add_q;
    logic [3:0]          tap_q;
    logic                sum_q, sum_d;
    logic                busy_q, busy_d;
    logic                drop_q, drop_d;

    logic [1:0]          wr_bank;
    logic [5:0]          wr_base;
    logic [ADDR_W-1:0]   wr_word;
    logic                wr_vld;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        flush_d = flush_q;
        case (state_q)
            ST_IDLE: begin
                if (iCoeffUpdateFlag) begin
                    state_d = ST_UPDATE;
                end else if (iEnSample600k) begin
                    state_d = ST_SHIFT;
                    n_d     = (iNumOfCoeff > 6'(NUM_TAPS)) ? 6'(NUM_TAPS) : iNumOfCoeff;
                end
            end
            ST_UPDATE: begin
                if (!iCoeffUpdateFlag) state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                state_d = ST_READ;
                k_d     = '0;
            end
            ST_READ: begin
                if (k_q == ADDR_W'(TAPS_PER_BANK - 1)) begin
                    state_d = ST_FLUSH;
                    flush_d = 1'b0;
                end else begin
                    k_d = k_q + ADDR_W'(1);
                end
            end
            ST_FLUSH: begin
                if (flush_q) state_d = ST_DONE;
                else         flush_d = 1'b1;
            end
            ST_DONE: begin
                state_d = iCoeffUpdateFlag ? ST_UPDATE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each registered enable lands in the cycle its state occupies.
    always_comb begin
        rd_act_d = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_act_d[b] = (state_d == ST_READ) &&
                          ((7'(k_d) + 7'(b * TAPS_PER_BANK)) < 7'(n_d));
        end
    end

    always_comb begin
        wr_bank = 2'd0;
        wr_base = 6'd0;
        if (iAddrRam >= 6'(3 * TAPS_PER_BANK)) begin
            wr_bank = 2'd3;
            wr_base = 6'(3 * TAPS_PER_BANK);
        end else if (iAddrRam >= 6'(2 * TAPS_PER_BANK)) begin
            wr_bank = 2'd2;
            wr_base = 6'(2 * TAPS_PER_BANK);
        end else if (iAddrRam >= 6'(TAPS_PER_BANK)) begin
            wr_bank = 2'd1;
            wr_base = 6'(TAPS_PER_BANK);
        end
        wr_word = ADDR_W'(iAddrRam - wr_base);
        wr_vld  = (state_q == ST_UPDATE) && iCoeffUpdateFlag && (iAddrRam < 6'(NUM_TAPS));
    end

    always_comb begin
        csn_d  = 4'hF;
        wrn_d  = 4'hF;
        addr_d = addr_q;
        wdt_d  = wdt_q;
        if (state_d == ST_READ) begin
            csn_d  = ~rd_act_d;
            addr_d = {NUM_BANKS{k_d}};
        end else if (wr_vld) begin
            csn_d[wr_bank] = 1'b0;
            wrn_d[wr_bank] = 1'b0;
            addr_d[wr_bank*ADDR_W +: ADDR_W] = wr_word;
            wdt_d = iWrDtRam;
        end
        dly_d  = (state_d == ST_SHIFT);
        acc_d  = (state_d == ST_SHIFT) ? 4'hF : 4'h0;
        sum_d  = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
        drop_d = iEnSample600k && ((state_q != ST_IDLE) || iCoeffUpdateFlag);
    end

    always_ff @(posedge iClk12M) begin
        if (iRsn) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            n_q      <= '0;
            flush_q  <= 1'b0;
            csn_q    <= 4'hF;
            wrn_q    <= 4'hF;
            addr_q   <= '0;
            wdt_q    <= '0;
            dly_q    <= 1'b0;
            acc_q    <= '0;
            rd_act_q <= '0;
            rd_k_q   <= '0;
            mul_q    <= '0;
            add_q    <= '0;
            tap_q    <= '0;
            sum_q    <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            n_q      <= n_d;
            flush_q  <= flush_d;
            csn_q    <= csn_d;
            wrn_q    <= wrn_d;
            addr_q   <= addr_d;
            wdt_q    <= wdt_d;
            dly_q    <= dly_d;
            acc_q    <= acc_d;
            rd_act_q <= rd_act_d;
            rd_k_q   <= k_d;
            // SRAM data arrives one cycle after the read; accumulate one cycle after the multiply.
            mul_q    <= rd_act_q;
            tap_q    <= rd_k_q;
            add_q    <= mul_q;
            sum_q    <= sum_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
        end
    end

    assign oCsnRam     = csn_q;
    assign oWrnRam     = wrn_q;
    assign oAddrRam    = addr_q;
    assign oWrDtRam    = wdt_q;
    assign oEnDelay    = dly_q;
    assign oEnAcc      = acc_q;
    assign oEnMul      = mul_q;
    assign oEnAdd      = add_q;
    assign oTapSel     = tap_q;
    assign oSumValid   = sum_q;
    assign oBusy       = busy_q;
    assign oSampleDrop = drop_q;

endmodule
